// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: default width, default reset PC and fetch FSM state encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_unit_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with flush, show-ahead head and occupancy count.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push while full is accepted only together with a pop; pop while empty is ignored.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       head_valid,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign full       = (count == CW'(DEPTH));
    assign do_pop     = pop && head_valid;
    assign do_push    = push && (!full || do_pop);
    // Gate the head so an empty buffer presents zeros rather than stale storage.
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one-outstanding word reads, buffers {pc, instr} for the datapath.
// Latency: request the cycle after reset release; word on inst_* the cycle after imem_rsp_valid.
// Backpressure: fetch pauses when buffered plus in-flight words reach FIFO_DEPTH; FETCH_PERF_CNT_EN adds counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stalls
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_nxt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_after;
    logic            accept;
    logic            push;
    logic            pop;
    logic [2*XLEN-1:0] head;

    assign imem_req_valid = (state == ST_REQ);
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign push           = (state == ST_WAIT) && imem_rsp_valid && !redirect_valid;
    assign pop            = inst_valid && inst_ready && !redirect_valid;
    // Occupancy once the arriving word lands, used to decide whether to fetch again.
    assign count_after    = count + CW'(1) - CW'(pop);
    assign {inst_pc, inst_data} = head;

    // fetch_pc has already advanced on acceptance, so the in-flight word sits one word behind it.
    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  ({fetch_pc - XLEN'(4), imem_rsp_data}),
        .pop        (pop),
        .head_valid (inst_valid),
        .head_data  (head),
        .count      (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        if (accept) fetch_pc_nxt = fetch_pc + XLEN'(4);
        case (state)
            ST_IDLE:    if (count < CW'(FIFO_DEPTH)) state_nxt = ST_REQ;
            ST_REQ:     if (accept) state_nxt = ST_WAIT;
            ST_WAIT:    if (imem_rsp_valid)
                            state_nxt = (count_after < CW'(FIFO_DEPTH)) ? ST_REQ : ST_IDLE;
            ST_DISCARD: if (imem_rsp_valid) state_nxt = ST_REQ;
            default:    state_nxt = ST_IDLE;
        endcase
        // A redirect overrides everything; any request already accepted must have its response dropped.
        if (redirect_valid) begin
            fetch_pc_nxt = redirect_pc & ~XLEN'(3);
            case (state)
                ST_IDLE:    state_nxt = ST_REQ;
                ST_REQ:     state_nxt = accept ? ST_DISCARD : ST_REQ;
                ST_WAIT:    state_nxt = imem_rsp_valid ? ST_REQ : ST_DISCARD;
                ST_DISCARD: state_nxt = imem_rsp_valid ? ST_REQ : ST_DISCARD;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
        end else begin
            if (push) perf_fetched <= perf_fetched + 32'd1;
            if (imem_req_valid && !imem_req_ready) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: directed phases push expected PCs, monitors pop and compare.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, rsp_valid, redirect_valid, inst_valid, inst_ready;
    logic [31:0] req_addr, rsp_data, redirect_pc, inst_data, inst_pc;
    logic        w_req_valid, w_rsp_valid, w_inst_valid;
    logic [31:0] w_req_addr, w_rsp_data, w_inst_data, w_inst_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stalls, w_perf_fetched, w_perf_stalls;
`endif

    int vectors = 0;
    int miscompares = 0;
    int pops = 0;
    int mem_lat = 1;
    logic [31:0] exp_q[$];
    logic [31:0] w_q[$];

    fetch_unit u_dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_req_addr  (req_addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stalls    (perf_stalls)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (1'b1),
        .imem_req_addr  (w_req_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .inst_valid     (w_inst_valid),
        .inst_ready     (1'b1),
        .inst_data      (w_inst_data),
        .inst_pc        (w_inst_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (w_perf_fetched),
        .perf_stalls    (w_perf_stalls)
`endif
    );

    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[15:0], 16'h0013} ^ {16'h0000, a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_pops(input int target, input string name);
        int n = 0;
        while (pops < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(pops >= target), 32'd1);
    endtask

    task automatic wait_accept(input string name);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            seen = (req_valid === 1'b1) && (req_ready === 1'b1);
            n++;
        end
        check(name, 32'(seen), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic load_wrap();
        w_q.delete();
        w_q.push_back(32'hFFFF_FFF8);
        w_q.push_back(32'hFFFF_FFFC);
        w_q.push_back(32'h0000_0000);
        w_q.push_back(32'h0000_0004);
    endtask

    // Instruction memory for the main DUT: fixed-order responses mem_lat cycles after acceptance.
    initial begin
        bit acc, pend;
        int pend_cnt;
        logic [31:0] acc_addr, pend_addr;
        pend = 1'b0;
        pend_cnt = 0;
        pend_addr = '0;
        rsp_valid = 1'b0;
        rsp_data = '0;
        forever begin
            @(negedge clk);
            acc = (reset === 1'b1) && (req_valid === 1'b1) && (req_ready === 1'b1);
            acc_addr = req_addr;
            @(posedge clk); #1;
            rsp_valid = 1'b0;
            rsp_data = '0;
            if (reset !== 1'b1) begin
                pend = 1'b0;
            end else begin
                if (acc) begin
                    pend = 1'b1;
                    pend_cnt = mem_lat;
                    pend_addr = acc_addr;
                end
                if (pend) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        rsp_valid = 1'b1;
                        rsp_data = img(pend_addr);
                        pend = 1'b0;
                    end
                end
            end
        end
    end

    // Always-ready, single-cycle memory for the wrap instance.
    initial begin
        bit acc;
        logic [31:0] a;
        w_rsp_valid = 1'b0;
        w_rsp_data = '0;
        forever begin
            @(negedge clk);
            acc = (reset === 1'b1) && (w_req_valid === 1'b1);
            a = w_req_addr;
            @(posedge clk); #1;
            w_rsp_valid = acc && (reset === 1'b1);
            w_rsp_data = acc ? img(a) : '0;
        end
    end

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1 && redirect_valid !== 1'b1) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("unexpected inst_pc", inst_pc, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_pc", inst_pc, e);
                    check("inst_data", inst_data, img(e));
                end
            end
        end
    end

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && w_inst_valid === 1'b1 && w_q.size() != 0) begin
                e = w_q.pop_front();
                check("wrap inst_pc", w_inst_pc, e);
                check("wrap inst_data", w_inst_data, img(e));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors applied", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, bad;
        reset = 1'b0;
        req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_valid", req_valid, 32'd0);
        check("reset req_addr", req_addr, 32'h0);
        check("reset inst_valid", inst_valid, 32'd0);
        check("reset inst_data", inst_data, 32'h0);
        check("reset inst_pc", inst_pc, 32'h0);
        check("reset wrap req_addr", w_req_addr, 32'hFFFF_FFF8);
`ifdef FETCH_PERF_CNT_EN
        check("reset perf_fetched", perf_fetched, 32'd0);
        check("reset perf_stalls", perf_stalls, 32'd0);
`endif

        // Streaming with the datapath always ready.
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
        load_wrap();
        reset = 1'b1;
        wait_pops(8, "stream pops");

        // Reset while a response is outstanding.
        wait_accept("accept before reset");
        reset = 1'b0;
        #1;
        check("mid reset req_valid", req_valid, 32'd0);
        check("mid reset req_addr", req_addr, 32'h0);
        check("mid reset inst_valid", inst_valid, 32'd0);
        check("mid reset inst_data", inst_data, 32'h0);
        check("mid reset inst_pc", inst_pc, 32'h0);
        exp_q.delete();
        w_q.delete();
        inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
        load_wrap();
        reset = 1'b1;

        // Datapath stalled: the buffer fills to depth and requests stop.
        repeat (20) @(posedge clk);
        #1;
        check("full req_valid", req_valid, 32'd0);
        check("full inst_valid", inst_valid, 32'd1);
        check("full head pc", inst_pc, 32'h0);

        // Drain with memory not ready: four pops, then five stalled request cycles at 0x10.
        base = pops;
        bad = 0;
        req_ready = 1'b0;
        inst_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k >= 2 && !(req_valid === 1'b1 && req_addr === 32'h10)) bad++;
        end
        check("stalled request held at 0x10", 32'(bad), 32'd0);
        check("drained words", 32'(pops - base), 32'd4);
`ifdef FETCH_PERF_CNT_EN
        check("perf_stalls", perf_stalls, 32'd5);
        check("perf_fetched", perf_fetched, 32'd4);
`endif
        @(posedge clk);
        #1;
        req_ready = 1'b1;
        mem_lat = 3;
        base = pops;
        wait_pops(base + 2, "resume pops");

        // Redirect while waiting on a response.
        wait_accept("accept before redirect");
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(i * 4));
        base = pops;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        @(negedge clk);
        check("flush inst_valid", inst_valid, 32'd0);
        check("discard req_valid", req_valid, 32'd0);
        wait_pops(base + 2, "post redirect pops");

        check("wrap words outstanding", 32'(w_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
